fir_seq_mac: RTL

FIR_SEQ_MAC -- requirements
Module: fir_seq_mac

---
 rtl/fir_seq_mac.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: one multiplier, time-shared across TAPS coefficients,
// with a valid/ready sample interface, rounding/saturating output and writable taps.
module fir_seq_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 2,
    localparam int AW    = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err,
    input  logic [AW-1:0]            coef_raddr,
    output logic signed [COEF_W-1:0] coef_rdata,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [AW:0]           TAPS_C  = (AW+1)'(TAPS);
    localparam logic [AW-1:0]         K_LAST  = AW'(TAPS - 1);
    localparam logic signed [ACC_W:0] RND     = (SHIFT > 0) ? (ACC_W+1)'(1) <<< RND_SH
                                                            : (ACC_W+1)'(0);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  x_dl_p0 [TAPS];
    logic signed [COEF_W-1:0]  coef_q  [TAPS];
    logic signed [ACC_W-1:0]   acc_p0;
    logic [AW-1:0]             k_p0;

    logic signed [PROD_W-1:0]  x_ext;
    logic signed [PROD_W-1:0]  h_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic [OUT_W:0]            res_sat;
    logic                      coef_ok;
    logic                      coef_bad;

    // Round half up, then arithmetic shift; one guard bit absorbs the rounding carry.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] ext;
        ext = {a[ACC_W-1], a};
        return (ext + RND) >>> SHIFT;
    endfunction

    // Returns {saturated, value} clamped to the signed OUT_W range.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        if (r < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    always_comb begin
        x_ext   = PROD_W'(x_dl_p0[k_p0]);
        h_ext   = PROD_W'(coef_q[k_p0]);
        prod    = x_ext * h_ext;
        acc_nxt = acc_p0 + ACC_W'(prod);
        res_sat = saturate(round_shift(acc_nxt));
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state == S_MAC);
    assign coef_ok    = coef_we && (state != S_MAC) && ({1'b0, coef_addr} < TAPS_C);
    assign coef_bad   = coef_we && !coef_ok;
    assign coef_rdata = ({1'b0, coef_raddr} < TAPS_C) ? coef_q[coef_raddr] : '0;

    // Coefficient bank: a write landing on the accept edge is seen by that sample's MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                coef_q[i] <= '0;
            coef_q[0] <= COEF_W'(1);
            coef_err  <= 1'b0;
        end else begin
            coef_err <= coef_bad;
            if (coef_ok)
                coef_q[coef_addr] <= coef_wdata;
        end
    end

    // Control FSM: accept -> TAPS multiply-accumulate cycles -> hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            for (int i = 0; i < TAPS; i++)
                x_dl_p0[i] <= '0;
            acc_p0    <= '0;
            k_p0      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_dl_p0[0] <= in_data;
                        for (int i = 1; i < TAPS; i++)
                            x_dl_p0[i] <= x_dl_p0[i-1];
                        acc_p0 <= '0;
                        k_p0   <= '0;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_p0 <= acc_nxt;
                    if (k_p0 == K_LAST) begin
                        k_p0      <= '0;
                        out_data  <= res_sat[OUT_W-1:0];
                        out_sat   <= res_sat[OUT_W];
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        k_p0 <= k_p0 + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
